// File: rtl/lynxTypes.sv
// Shared RoCE read-path types: beat geometry, command field widths and the
// responder FSM state encoding.
package lynxTypes;

   localparam int BEAT_BYTES = 64;
   localparam int BEAT_SHIFT = 6;
   localparam int VADDR_BITS = 48;
   localparam int LEN_BITS   = 28;
   // ceil(len/64) for a 28-bit length needs one bit more than len[27:6]
   localparam int BEATS_BITS = LEN_BITS - BEAT_SHIFT + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      STREAM = 2'd2
   } rd_state_t;

   // Number of 64-byte beats covering a byte length (rounded up).
   function automatic logic [BEATS_BITS-1:0] beats_of(input logic [LEN_BITS-1:0] len);
      return BEATS_BITS'(len[LEN_BITS-1:BEAT_SHIFT]) +
             BEATS_BITS'(len[BEAT_SHIFT-1:0] != '0);
   endfunction

endpackage

// File: rtl/rdma_rd_skid.sv
// Two-entry output FIFO for the read-data stream. Reports how many slots are
// free so the producer can issue buffer reads only when a landing slot exists.
module rdma_rd_skid #(
   parameter int DATA_BITS = 512
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic [DATA_BITS-1:0]   i_data,
   input  logic [DATA_BITS/8-1:0] i_keep,
   input  logic                   i_last,
   input  logic                   i_ready,
   output logic                   o_valid,
   output logic [DATA_BITS-1:0]   o_data,
   output logic [DATA_BITS/8-1:0] o_keep,
   output logic                   o_last,
   output logic [1:0]             o_free
);

   localparam int KEEP_W = DATA_BITS / 8;

   logic [DATA_BITS-1:0] r_data [2];
   logic [KEEP_W-1:0]    r_keep [2];
   logic                 r_last [2];
   logic                 r_wr_ptr;
   logic                 r_rd_ptr;
   logic [1:0]           r_cnt;
   logic                 w_push;
   logic                 w_pop;

   assign w_pop  = (r_cnt != 2'd0) && i_ready;
   assign w_push = i_push && (r_cnt != 2'd2);

   // Storage, pointers and occupancy; entries clear on reset so the stream
   // outputs read as zero while reset is held.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_cnt    <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_data[i] <= '0;
            r_keep[i] <= '0;
            r_last[i] <= 1'b0;
         end
      end else begin
         if (w_push) begin
            r_data[r_wr_ptr] <= i_data;
            r_keep[r_wr_ptr] <= i_keep;
            r_last[r_wr_ptr] <= i_last;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: ;
         endcase
      end
   end

   assign o_valid = (r_cnt != 2'd0);
   assign o_data  = r_data[r_rd_ptr];
   assign o_keep  = r_keep[r_rd_ptr];
   assign o_last  = r_last[r_rd_ptr];
   assign o_free  = 2'd2 - r_cnt;

endmodule

// File: rtl/rdma_rd_responder.sv
// RoCE memory-read responder: accepts a read command, streams the addressed
// beats out of a local dual-port buffer, and keeps accept/reject counters.
module rdma_rd_responder
   import lynxTypes::*;
#(
   parameter int DATA_BITS = 512,
   parameter int MEM_DEPTH = 1024
) (
   input  logic                         nclk,
   input  logic                         nrst,
   input  logic                         s_rd_req_valid,
   output logic                         s_rd_req_ready,
   input  logic [VADDR_BITS-1:0]        s_rd_req_vaddr,
   input  logic [LEN_BITS-1:0]          s_rd_req_len,
   output logic                         m_axis_rd_tvalid,
   input  logic                         m_axis_rd_tready,
   output logic [DATA_BITS-1:0]         m_axis_rd_tdata,
   output logic [DATA_BITS/8-1:0]       m_axis_rd_tkeep,
   output logic                         m_axis_rd_tlast,
   input  logic                         wr_en,
   input  logic [$clog2(MEM_DEPTH)-1:0] wr_addr,
   input  logic [DATA_BITS-1:0]         wr_data,
   output logic                         busy,
   output logic [31:0]                  req_count,
   output logic [31:0]                  err_count
);

   localparam int MEM_ABITS = $clog2(MEM_DEPTH);
   localparam int KEEP_W    = DATA_BITS / 8;

   rd_state_t               r_state;
   logic                    r_ready;
   logic                    r_busy;
   logic [31:0]             r_req_cnt;
   logic [31:0]             r_err_cnt;
   logic [MEM_ABITS-1:0]    r_beat_addr;
   logic [BEATS_BITS-1:0]   r_left;
   logic [BEAT_SHIFT-1:0]   r_tail;

   logic [DATA_BITS-1:0]    r_mem [MEM_DEPTH];
   logic [DATA_BITS-1:0]    r_rd_data_p1;
   logic [KEEP_W-1:0]       r_keep_p1;
   logic                    r_last_p1;
   logic                    r_rd_vld_p1;

   logic                    w_accept;
   logic                    w_bad;
   logic                    w_pop;
   logic                    w_issue;
   logic                    w_issue_last;
   logic [KEEP_W-1:0]       w_keep_p0;
   logic [1:0]              w_free;
   logic                    w_unused_vaddr;

   // Byte enables for the final beat: low (len mod 64) bytes, or all bytes
   // when the length is a whole number of beats.
   function automatic logic [KEEP_W-1:0] last_keep(input logic [BEAT_SHIFT-1:0] tail);
      logic [KEEP_W-1:0] k;
      for (int i = 0; i < KEEP_W; i++) begin
         k[i] = (tail == '0) || (i < int'(tail));
      end
      return k;
   endfunction

   assign w_accept     = s_rd_req_valid && r_ready;
   assign w_bad        = (s_rd_req_len == '0) || (s_rd_req_vaddr[BEAT_SHIFT-1:0] != '0);
   assign w_pop        = m_axis_rd_tvalid && m_axis_rd_tready;
   assign w_issue_last = (r_left == BEATS_BITS'(1));
   assign w_keep_p0    = w_issue_last ? last_keep(r_tail) : '1;
   // A read may issue only if, after this cycle's pop, the FIFO still has a
   // free slot beyond the one reserved by the read already in flight.
   assign w_issue      = (r_state == FETCH) &&
                         (({1'b0, w_free} + {2'b00, w_pop}) > {2'b00, r_rd_vld_p1});
   assign w_unused_vaddr = ^s_rd_req_vaddr[VADDR_BITS-1:BEAT_SHIFT+MEM_ABITS];

   // Command FSM with registered ready/busy and the accept/reject counters.
   always_ff @(posedge nclk or posedge nrst) begin
      if (nrst) begin
         r_state     <= IDLE;
         r_ready     <= 1'b0;
         r_busy      <= 1'b0;
         r_req_cnt   <= 32'd0;
         r_err_cnt   <= 32'd0;
         r_beat_addr <= '0;
         r_left      <= '0;
         r_tail      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_ready <= 1'b1;
               if (w_accept) begin
                  if (w_bad) begin
                     r_err_cnt <= r_err_cnt + 32'd1;
                  end else begin
                     r_req_cnt   <= r_req_cnt + 32'd1;
                     r_beat_addr <= s_rd_req_vaddr[BEAT_SHIFT +: MEM_ABITS];
                     r_left      <= beats_of(s_rd_req_len);
                     r_tail      <= s_rd_req_len[BEAT_SHIFT-1:0];
                     r_ready     <= 1'b0;
                     r_busy      <= 1'b1;
                     r_state     <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (w_issue) begin
                  r_beat_addr <= r_beat_addr + 1'b1;
                  r_left      <= r_left - 1'b1;
                  if (w_issue_last) begin
                     r_state <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (w_pop && m_axis_rd_tlast) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Buffer: fill port and read-first read port (old data wins on collision).
   // Stage p0 -> p1: read data and its beat metadata register together.
   always_ff @(posedge nclk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
      if (w_issue) begin
         r_rd_data_p1 <= r_mem[r_beat_addr];
         r_keep_p1    <= w_keep_p0;
         r_last_p1    <= w_issue_last;
      end
   end

   // Stage p1 valid: a reset drops any read in flight.
   always_ff @(posedge nclk or posedge nrst) begin
      if (nrst) begin
         r_rd_vld_p1 <= 1'b0;
      end else begin
         r_rd_vld_p1 <= w_issue;
      end
   end

   rdma_rd_skid #(
      .DATA_BITS (DATA_BITS)
   ) u_skid (
      .i_clk   (nclk),
      .i_rst   (nrst),
      .i_push  (r_rd_vld_p1),
      .i_data  (r_rd_data_p1),
      .i_keep  (r_keep_p1),
      .i_last  (r_last_p1),
      .i_ready (m_axis_rd_tready),
      .o_valid (m_axis_rd_tvalid),
      .o_data  (m_axis_rd_tdata),
      .o_keep  (m_axis_rd_tkeep),
      .o_last  (m_axis_rd_tlast),
      .o_free  (w_free)
   );

   assign s_rd_req_ready = r_ready;
   assign busy           = r_busy;
   assign req_count      = r_req_cnt;
   assign err_count      = r_err_cnt;

endmodule

// File: tb/tb_rdma_rd_responder.sv
// Bench for rdma_rd_responder: directed and randomized read commands checked
// against a beat-list model derived from the command rules.
module tb_rdma_rd_responder;

   localparam int DB    = 512;
   localparam int DEPTH = 1024;
   localparam int AB    = 10;

   logic            nclk = 1'b0;
   logic            nrst;
   logic            s_valid;
   logic            s_ready;
   logic [47:0]     s_vaddr;
   logic [27:0]     s_len;
   logic            m_tvalid;
   logic            m_tready;
   logic [DB-1:0]   m_tdata;
   logic [DB/8-1:0] m_tkeep;
   logic            m_tlast;
   logic            wr_en;
   logic [AB-1:0]   wr_addr;
   logic [DB-1:0]   wr_data;
   logic            busy;
   logic [31:0]     req_count;
   logic [31:0]     err_count;

   rdma_rd_responder #(.DATA_BITS(DB), .MEM_DEPTH(DEPTH)) dut (
      .nclk             (nclk),
      .nrst             (nrst),
      .s_rd_req_valid   (s_valid),
      .s_rd_req_ready   (s_ready),
      .s_rd_req_vaddr   (s_vaddr),
      .s_rd_req_len     (s_len),
      .m_axis_rd_tvalid (m_tvalid),
      .m_axis_rd_tready (m_tready),
      .m_axis_rd_tdata  (m_tdata),
      .m_axis_rd_tkeep  (m_tkeep),
      .m_axis_rd_tlast  (m_tlast),
      .wr_en            (wr_en),
      .wr_addr          (wr_addr),
      .wr_data          (wr_data),
      .busy             (busy),
      .req_count        (req_count),
      .err_count        (err_count)
   );

   always #5 nclk = ~nclk;

   int cyc = 0;
   always @(posedge nclk) cyc <= cyc + 1;

   typedef struct {
      logic [DB-1:0]   d;
      logic [DB/8-1:0] k;
      logic            l;
      int              c;
   } beat_t;

   beat_t       obs_q[$];
   beat_t       exp_q[$];
   logic [DB-1:0] mem_m [DEPTH];
   int          exp_req = 0;
   int          exp_err = 0;
   int          first_tv = -1;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Stream monitor: records handshaken beats and checks stall stability.
   logic  st_pend = 1'b0;
   beat_t held;
   beat_t mon_b;
   always @(negedge nclk) begin
      if (nrst) begin
         st_pend = 1'b0;
      end else begin
         if (st_pend) begin
            chk("stall_tvalid", m_tvalid, 1'b1);
            chk("stall_tdata", m_tdata, held.d);
            chk("stall_tkeep", m_tkeep, held.k);
            chk("stall_tlast", m_tlast, held.l);
         end
         if (m_tvalid && first_tv < 0) first_tv = cyc;
         if (m_tvalid && m_tready) begin
            mon_b.d = m_tdata;
            mon_b.k = m_tkeep;
            mon_b.l = m_tlast;
            mon_b.c = cyc;
            obs_q.push_back(mon_b);
         end
         st_pend = m_tvalid && !m_tready;
         held.d  = m_tdata;
         held.k  = m_tkeep;
         held.l  = m_tlast;
      end
   end

   // Reference model: the beats a command must produce, from buffer contents.
   task automatic model_cmd(input logic [47:0] va, input int len);
      int    n;
      int    tail;
      int    start;
      beat_t b;
      if (len == 0 || va[5:0] != 6'd0) begin
         exp_err++;
         return;
      end
      exp_req++;
      n     = (len + 63) / 64;
      tail  = len % 64;
      start = int'((va >> 6) % DEPTH);
      for (int k = 0; k < n; k++) begin
         b.d = mem_m[(start + k) % DEPTH];
         b.l = (k == n - 1);
         if (k == n - 1 && tail != 0) b.k = (64'd1 << tail) - 64'd1;
         else b.k = '1;
         b.c = 0;
         exp_q.push_back(b);
      end
   endtask

   task automatic send(input logic [47:0] va, input int len, input bit collide,
                       input logic [DB-1:0] newv, output int acc);
      int t;
      @(posedge nclk); #1;
      s_valid  = 1'b1;
      s_vaddr  = va;
      s_len    = 28'(len);
      first_tv = -1;
      for (t = 0; t < 50; t++) begin
         @(negedge nclk);
         if (s_ready) break;
      end
      chk("accept_ready", s_ready, 1'b1);
      acc = cyc + 1;
      @(posedge nclk); #1;
      s_valid = 1'b0;
      if (collide) begin
         wr_en   = 1'b1;
         wr_addr = AB'((va >> 6) % DEPTH);
         wr_data = newv;
         @(posedge nclk); #1;
         wr_en = 1'b0;
         mem_m[(va >> 6) % DEPTH] = newv;
      end
   endtask

   task automatic collect(input bit rnd, input int acc);
      int t;
      int n;
      for (t = 0; t < 3000; t++) begin
         @(posedge nclk); #1;
         m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (obs_q.size() >= exp_q.size() && !busy) break;
      end
      m_tready = 1'b1;
      repeat (3) @(posedge nclk);
      #1;
      chk("beat_count", obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int k = 0; k < n; k++) begin
         chk("beat_data", obs_q[k].d, exp_q[k].d);
         chk("beat_keep", obs_q[k].k, exp_q[k].k);
         chk("beat_last", obs_q[k].l, exp_q[k].l);
      end
      chk("req_count", req_count, exp_req);
      chk("err_count", err_count, exp_err);
      chk("ready_after", s_ready, 1'b1);
      if (!rnd && n > 0) begin
         chk("first_tvalid_cyc", first_tv, acc + 2);
         chk("no_bubble", obs_q[n-1].c - obs_q[0].c, n - 1);
      end
   endtask

   task automatic clear_q();
      obs_q.delete();
      exp_q.delete();
   endtask

   int          acc;
   logic [47:0] va;
   int          len;
   int          lens [4] = '{1, 63, 64, 65};
   logic [DB-1:0] newv;

   initial begin
      nrst     = 1'b1;
      s_valid  = 1'b0;
      s_vaddr  = '0;
      s_len    = '0;
      m_tready = 1'b1;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      repeat (3) @(posedge nclk);
      #1;
      chk("rst_ready", s_ready, 1'b0);
      chk("rst_tvalid", m_tvalid, 1'b0);
      chk("rst_tlast", m_tlast, 1'b0);
      chk("rst_tkeep", m_tkeep, '0);
      chk("rst_tdata", m_tdata, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_req_count", req_count, 32'd0);
      chk("rst_err_count", err_count, 32'd0);
      nrst = 1'b0;
      chk("ready_at_release", s_ready, 1'b0);
      @(posedge nclk); #1;
      chk("ready_first_clk", s_ready, 1'b1);

      // fill beat i with value i
      for (int i = 0; i < DEPTH; i++) begin
         wr_en   = 1'b1;
         wr_addr = AB'(i);
         wr_data = DB'(i);
         mem_m[i] = DB'(i);
         @(posedge nclk); #1;
      end
      wr_en = 1'b0;

      // four full beats from address 0
      model_cmd(48'h0, 256);
      send(48'h0, 256, 1'b0, '0, acc);
      chk("busy_in_cmd", busy, 1'b1);
      chk("ready_low_in_cmd", s_ready, 1'b0);
      collect(1'b0, acc);
      chk("r26_req_count", req_count, 32'd1);
      clear_q();

      // partial last beat
      model_cmd(48'h40, 100);
      send(48'h40, 100, 1'b0, '0, acc);
      collect(1'b0, acc);
      if (obs_q.size() == 2) begin
         chk("r27_data0", obs_q[0].d, DB'(1));
         chk("r27_keep1", obs_q[1].k, 64'h0000000F_FFFFFFFF);
      end
      clear_q();

      // address wrap at the end of the buffer
      model_cmd(48'((DEPTH - 1) * 64), 128);
      send(48'((DEPTH - 1) * 64), 128, 1'b0, '0, acc);
      collect(1'b0, acc);
      if (obs_q.size() == 2) begin
         chk("r28_wrap0", obs_q[0].d, DB'(DEPTH - 1));
         chk("r28_wrap1", obs_q[1].d, DB'(0));
      end
      clear_q();

      // rejected commands: zero length, misaligned address
      model_cmd(48'h0, 0);
      send(48'h0, 0, 1'b0, '0, acc);
      chk("rej0_ready", s_ready, 1'b1);
      repeat (4) begin
         @(posedge nclk); #1;
         chk("rej0_no_tvalid", m_tvalid, 1'b0);
         chk("rej0_ready_hold", s_ready, 1'b1);
      end
      model_cmd(48'h21, 64);
      send(48'h21, 64, 1'b0, '0, acc);
      chk("rej1_ready", s_ready, 1'b1);
      repeat (4) begin
         @(posedge nclk); #1;
         chk("rej1_no_tvalid", m_tvalid, 1'b0);
         chk("rej1_ready_hold", s_ready, 1'b1);
      end
      collect(1'b0, acc);
      chk("r29_err_count", err_count, 32'd2);
      clear_q();

      // read/write collision on beat 2: old value streams, new value next time
      newv = {16{32'hC0DE_0002}};
      model_cmd(48'h80, 64);
      send(48'h80, 64, 1'b1, newv, acc);
      collect(1'b0, acc);
      if (obs_q.size() == 1) chk("r31_old", obs_q[0].d, DB'(2));
      clear_q();
      model_cmd(48'h80, 64);
      send(48'h80, 64, 1'b0, '0, acc);
      collect(1'b0, acc);
      if (obs_q.size() == 1) chk("r31_new", obs_q[0].d, newv);
      clear_q();

      // length boundaries and random commands with random back-pressure
      for (int i = 0; i < 4; i++) begin
         va = {16'($urandom), 32'($urandom)};
         va[5:0] = 6'd0;
         model_cmd(va, lens[i]);
         send(va, lens[i], 1'b0, '0, acc);
         collect(1'b0, acc);
         clear_q();
      end
      for (int i = 0; i < 6; i++) begin
         va = {16'($urandom), 32'($urandom)};
         va[5:0] = 6'd0;
         len = int'($urandom_range(1, 700));
         model_cmd(va, len);
         send(va, len, 1'b0, '0, acc);
         collect(1'b1, acc);
         clear_q();
      end

      // ten beats under random tready
      model_cmd(48'h0, 640);
      send(48'h0, 640, 1'b0, '0, acc);
      collect(1'b1, acc);
      clear_q();

      // repeat, then reset after the fifth beat
      send(48'h0, 640, 1'b0, '0, acc);
      for (int t = 0; t < 2000; t++) begin
         @(posedge nclk); #1;
         m_tready = 1'($urandom_range(0, 1));
         if (obs_q.size() >= 5) break;
      end
      chk("beats_before_rst", obs_q.size(), 5);
      #2;
      nrst = 1'b1;
      #1;
      chk("midrst_tvalid", m_tvalid, 1'b0);
      chk("midrst_tlast", m_tlast, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_ready", s_ready, 1'b0);
      chk("midrst_req_count", req_count, 32'd0);
      exp_req = 0;
      exp_err = 0;
      @(posedge nclk); #1;
      nrst = 1'b0;
      chk("rel_ready_now", s_ready, 1'b0);
      @(posedge nclk); #1;
      chk("rel_ready_next", s_ready, 1'b1);
      m_tready = 1'b1;
      repeat (10) @(posedge nclk);
      #1;
      chk("no_beats_after_rst", obs_q.size(), 5);
      clear_q();

      // buffer contents survive reset
      model_cmd(48'h0, 128);
      send(48'h0, 128, 1'b0, '0, acc);
      collect(1'b0, acc);
      clear_q();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rdma_rd_responder.md
RDMA_RD_RESPONDER -- requirements
Module: rdma_rd_responder

Interface
REQ-001 SHALL have parameter DATA_BITS, default 512, meaning the read-data beat width; beat size is 64 bytes.
REQ-002 SHALL have parameter MEM_DEPTH, default 1024, meaning the number of beats in the local buffer (power of 2); MEM_ABITS = log2(MEM_DEPTH).
REQ-003 SHALL have ports, one per line:
- nclk  in  1  sole clock.
- nrst  in  1  reset, asynchronous, active-high.
- s_rd_req_valid / s_rd_req_ready  in / out  1 each  read-command handshake (the RoCE memory read command).
- s_rd_req_vaddr  in  48  byte address.
- s_rd_req_len  in  28  byte length.
- m_axis_rd_tvalid / m_axis_rd_tready  out / in  1 each  read-data stream toward the RoCE stack.
- m_axis_rd_tdata  out  DATA_BITS  beat data.
- m_axis_rd_tkeep  out  DATA_BITS/8  byte enables.
- m_axis_rd_tlast  out  1  last beat.
- wr_en  in  1  buffer fill strobe.
- wr_addr  in  MEM_ABITS  fill beat address.
- wr_data  in  DATA_BITS  fill data.
- busy  out  1  command in progress.
- req_count  out  32  accepted valid commands.
- err_count  out  32  rejected commands.

Function
REQ-004 SHALL implement FSM states IDLE, FETCH, STREAM.
REQ-005 SHALL assert s_rd_req_ready only in IDLE; a command is accepted on valid&&ready.
REQ-006 SHALL reject a command when len==0 or vaddr[5:0]!=0: increment err_count, emit no beats, and stay in IDLE.
REQ-007 SHALL, on a valid command, latch start beat = vaddr[6+:MEM_ABITS] and beats = ceil(len/64), increment req_count, and go to FETCH.
REQ-008 SHALL issue buffer reads with 1-cycle latency; the beat address increments per issued read and wraps modulo MEM_DEPTH.
REQ-009 SHALL present the first tvalid exactly 2 cycles after the accept cycle when tready is high.
REQ-010 SHALL sustain one beat per cycle while tready is held high, with no bubbles between beats of one command.
REQ-011 SHALL hold tdata, tkeep and tlast stable while tvalid && !tready, and SHALL NOT drop tvalid before the handshake.
REQ-012 SHALL drive tkeep all-ones on non-last beats; on the last beat SHALL drive the low (len mod 64) bits set, or all-ones when (len mod 64)==0.
REQ-013 SHALL assert tlast only on beat number beats-1; a single-beat command has tlast on its first beat.
REQ-014 SHALL issue no buffer read unless a free output-buffer slot is guaranteed (credit check), so no beat is ever lost.
REQ-015 SHALL return to IDLE in the cycle after the tlast handshake; s_rd_req_ready rises in that cycle.
REQ-016 SHALL make the buffer read-first: a write to the address being read in the same cycle returns the old data; the write is still performed.
REQ-017 SHALL accept wr_en in any state.
REQ-018 SHALL assert busy in FETCH and STREAM.
REQ-019 SHALL let req_count and err_count wrap modulo 2^32.

Reset
REQ-020 SHALL, while nrst is high, hold: FSM=IDLE, s_rd_req_ready=0, tvalid=0, tlast=0, tkeep=0, tdata=0, busy=0, both counters=0, output buffer empty.
REQ-021 SHALL, on reset asserted mid-burst, drop tvalid asynchronously and discard the remaining beats; buffer contents are not cleared.
REQ-022 SHALL assert s_rd_req_ready in the first clock after nrst deasserts.

Structure
REQ-023 SHALL place the beat-size constant (64), the address and length widths (48/28), and the FSM state enum in the shared lynxTypes package.
REQ-024 SHALL use one sub-module, rdma_rd_skid: a 2-entry output FIFO carrying tdata, tkeep and tlast, with a full/credit output.
REQ-025 SHALL infer the buffer as simple dual-port RAM inside rdma_rd_responder.

Verification
REQ-026 Fill beat i with i; command vaddr=0x0, len=256, tready=1 -> 4 beats with data 0..3, tlast on beat 3, tkeep all-ones, first tvalid at accept+2, req_count=1.
REQ-027 Command vaddr=0x40, len=100 -> 2 beats with data 1,2; beat 1 has tkeep=0x0000000F_FFFFFFFF and tlast=1.
REQ-028 Command vaddr=(MEM_DEPTH-1)*64, len=128 -> beats with data MEM_DEPTH-1 then 0 (wrap).
REQ-029 Command len=0, then command vaddr=0x21 -> no tvalid, err_count=2, s_rd_req_ready high throughout.
REQ-030 Command len=640 with tready toggling randomly -> 10 beats in order, each stable while stalled; assert nrst at beat 5 of a repeat run -> tvalid=0 immediately, ready=1 one clock after release.
REQ-031 Same-cycle wr_en to a beat address being read -> stream shows the old value; a subsequent command shows the new value.
